// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline memory stage: opcode constants for
// the load/store instructions, default data-memory geometry, the byte-enable
// type used by the data RAM, an access-size enum and an alignment helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pkg;

  // Default data-memory geometry: 4096 words of 32 bits = 16 KiB
  localparam int DM_WORDS_DEF = 4096;
  localparam int ADDR_W_DEF   = 12;

  // Load / store opcodes (Instr[31:26])
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  // One enable bit per byte lane, bit 0 = bits [7:0]
  typedef logic [3:0] be_t;

  // Width of the memory access implied by the opcode
  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_e;

  // True when an access of the given size starts on a byte lane it may not
  // start on; byte accesses are always aligned.
  function automatic logic accessMisaligned(acc_size_e size, logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_WORD: mis = (lane != 2'b00);
      SZ_HALF: mis = lane[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Bundles the EX/MEM outputs consumed by the memory stage and the MEM/WB
// register outputs it produces.
//   *_M signals : instruction, store data, address, PC+8, write-back address
//                 of the instruction currently in MEM, plus Misalign_M
//   *_W signals : MEM/WB pipeline register contents
// Modport slave is the memory stage itself; master is the surrounding
// pipeline (EX/MEM register upstream, write-back stage downstream).
// ---------------------------------------------------------------------------
interface mem_stage_if;
  logic [31:0] Instr_M;
  logic [31:0] RT_M;
  logic [31:0] ALU_M;
  logic [31:0] PC8_M;
  logic [4:0]  WBA_M;
  logic        Misalign_M;

  logic [31:0] Instr_W;
  logic [31:0] ALU_W;
  logic [31:0] DM_W;
  logic [31:0] PC8_W;
  logic [4:0]  WBA_W;
  logic        Exc_W;

  modport slave (
    input  Instr_M, RT_M, ALU_M, PC8_M, WBA_M,
    output Misalign_M,
    output Instr_W, ALU_W, DM_W, PC8_W, WBA_W, Exc_W
  );

  modport master (
    output Instr_M, RT_M, ALU_M, PC8_M, WBA_M,
    input  Misalign_M,
    input  Instr_W, ALU_W, DM_W, PC8_W, WBA_W, Exc_W
  );
endinterface

// File: rtl/dm_ram.sv
// ---------------------------------------------------------------------------
// dm_ram
// DM_WORDS x 32-bit data memory.
//   clk       : write/clear clock
//   reset     : synchronous, active-high; clears every word
//   addr_i    : word index for both read and write
//   be_i      : per-lane write enables (0 = no write)
//   wdata_i   : write data, already replicated onto the enabled lanes
//   rdata_o   : combinational read of word addr_i
// ---------------------------------------------------------------------------
module dm_ram
  import mips_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_i,
  input  be_t               be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DM_WORDS];

  // Reset wipes the whole array and takes priority over any write presented
  // in the same cycle; otherwise only the enabled lanes are updated.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the five-stage MIPS pipeline. Decodes load/store
// opcodes, performs byte/halfword/word accesses to the internal data memory,
// extends load data and registers everything into the MEM/WB register.
//   clk   : pipeline clock
//   reset : synchronous, active-high; zeroes MEM/WB and the data memory
//   bus   : mem_stage_if.slave -- *_M inputs, Misalign_M, *_W outputs
// ---------------------------------------------------------------------------
module mem_stage
  import mips_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  logic [5:0]        opcode;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] wordIdx;
  logic              isLoad;
  logic              isStore;
  logic              signExt;
  acc_size_e         accSize;
  logic              misalign;
  be_t               be;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [15:0]       halfSel;
  logic [7:0]        byteSel;
  logic [31:0]       loadData;

  logic [31:0] instr_q, instr_d;
  logic [31:0] alu_q,   alu_d;
  logic [31:0] dm_q,    dm_d;
  logic [31:0] pc8_q,   pc8_d;
  logic [4:0]  wba_q,   wba_d;
  logic        exc_q,   exc_d;

  assign opcode  = bus.Instr_M[31:26];
  assign lane    = bus.ALU_M[1:0];
  assign wordIdx = bus.ALU_M[ADDR_W+1:2];

  // Opcode decode: classify as load/store, access width and extension kind.
  always_comb begin
    isLoad  = 1'b0;
    isStore = 1'b0;
    signExt = 1'b0;
    accSize = SZ_NONE;
    case (opcode)
      OP_LW:  begin isLoad  = 1'b1; accSize = SZ_WORD; end
      OP_LH:  begin isLoad  = 1'b1; accSize = SZ_HALF; signExt = 1'b1; end
      OP_LHU: begin isLoad  = 1'b1; accSize = SZ_HALF; end
      OP_LB:  begin isLoad  = 1'b1; accSize = SZ_BYTE; signExt = 1'b1; end
      OP_LBU: begin isLoad  = 1'b1; accSize = SZ_BYTE; end
      OP_SW:  begin isStore = 1'b1; accSize = SZ_WORD; end
      OP_SH:  begin isStore = 1'b1; accSize = SZ_HALF; end
      OP_SB:  begin isStore = 1'b1; accSize = SZ_BYTE; end
      default: ;
    endcase
  end

  // Non-memory opcodes decode to SZ_NONE, which is never misaligned.
  assign misalign       = accessMisaligned(accSize, lane);
  assign bus.Misalign_M = misalign;

  // Store path: replicate the store data onto every lane and let the byte
  // enables pick the lanes that actually change. A misaligned store is
  // suppressed entirely.
  always_comb begin
    be    = 4'b0000;
    wdata = bus.RT_M;
    case (accSize)
      SZ_HALF: wdata = {2{bus.RT_M[15:0]}};
      SZ_BYTE: wdata = {4{bus.RT_M[7:0]}};
      default: wdata = bus.RT_M;
    endcase
    if (isStore && !misalign) begin
      case (accSize)
        SZ_WORD: be = 4'b1111;
        SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
        SZ_BYTE: be = 4'b0001 << lane;
        default: be = 4'b0000;
      endcase
    end
  end

  dm_ram #(
    .DM_WORDS (DM_WORDS),
    .ADDR_W   (ADDR_W)
  ) u_dm_ram (
    .clk     (clk),
    .reset   (reset),
    .addr_i  (wordIdx),
    .be_i    (be),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  // Load path: select the addressed lane(s) and extend. Misaligned loads and
  // non-load instructions return zero.
  always_comb begin
    halfSel  = lane[1] ? rdata[31:16] : rdata[15:0];
    byteSel  = rdata[7:0];
    loadData = '0;
    case (lane)
      2'd0: byteSel = rdata[7:0];
      2'd1: byteSel = rdata[15:8];
      2'd2: byteSel = rdata[23:16];
      2'd3: byteSel = rdata[31:24];
      default: byteSel = rdata[7:0];
    endcase
    if (isLoad && !misalign) begin
      case (accSize)
        SZ_WORD: loadData = rdata;
        SZ_HALF: loadData = {{16{signExt & halfSel[15]}}, halfSel};
        SZ_BYTE: loadData = {{24{signExt & byteSel[7]}}, byteSel};
        default: loadData = '0;
      endcase
    end
  end

  // MEM/WB next-state: the stage never stalls, so every field follows MEM.
  always_comb begin
    instr_d = bus.Instr_M;
    alu_d   = bus.ALU_M;
    dm_d    = loadData;
    pc8_d   = bus.PC8_M;
    wba_d   = bus.WBA_M;
    exc_d   = misalign;
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      alu_q   <= '0;
      dm_q    <= '0;
      pc8_q   <= '0;
      wba_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      alu_q   <= alu_d;
      dm_q    <= dm_d;
      pc8_q   <= pc8_d;
      wba_q   <= wba_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.Instr_W = instr_q;
  assign bus.ALU_W   = alu_q;
  assign bus.DM_W    = dm_q;
  assign bus.PC8_W   = pc8_q;
  assign bus.WBA_W   = wba_q;
  assign bus.Exc_W   = exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. A byte-array model of the 16 KiB data
// memory predicts load data, misalignment and the MEM/WB contents; directed
// steps follow the bring-up sequence, then randomized traffic is applied.
// ---------------------------------------------------------------------------
module tb_mem_stage;
  import mips_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_stage_if bus ();

  mem_stage #(
    .DM_WORDS (4096),
    .ADDR_W   (12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 16384 bytes, byte address = ALU mod 16 KiB
  logic [7:0] refMem [16384];

  function automatic int wrapAddr(logic [31:0] a);
    return int'(a[13:0]);
  endfunction

  function automatic logic refMisaligned(logic [5:0] op, logic [31:0] a);
    int w;
    w = 0;
    if (op == OP_LW || op == OP_SW) w = 4;
    else if (op == OP_LH || op == OP_LHU || op == OP_SH) w = 2;
    else w = 1;
    return (int'(a[1:0]) % w) != 0;
  endfunction

  function automatic logic [31:0] refLoad(logic [5:0] op, logic [31:0] a);
    int b;
    logic [15:0] h;
    logic [7:0]  y;
    b = wrapAddr(a);
    if (refMisaligned(op, a)) return 32'h0;
    case (op)
      OP_LW:  return {refMem[b+3], refMem[b+2], refMem[b+1], refMem[b]};
      OP_LH:  begin h = {refMem[b+1], refMem[b]}; return 32'(signed'(h)); end
      OP_LHU: begin h = {refMem[b+1], refMem[b]}; return {16'h0, h}; end
      OP_LB:  begin y = refMem[b]; return 32'(signed'(y)); end
      OP_LBU: begin y = refMem[b]; return {24'h0, y}; end
      default: return 32'h0;
    endcase
  endfunction

  task automatic refStore(logic [5:0] op, logic [31:0] a, logic [31:0] rt);
    int b;
    b = wrapAddr(a);
    if (refMisaligned(op, a)) return;
    case (op)
      OP_SW: for (int k = 0; k < 4; k++) refMem[b+k] = rt[8*k +: 8];
      OP_SH: for (int k = 0; k < 2; k++) refMem[b+k] = rt[8*k +: 8];
      OP_SB: refMem[b] = rt[7:0];
      default: ;
    endcase
  endtask

  task automatic refClear();
    for (int i = 0; i < 16384; i++) refMem[i] = 8'h00;
  endtask

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive MEM inputs, check Misalign_M in the same cycle,
  // then check the MEM/WB register after the rising edge.
  task automatic applyStimulus(logic [5:0] op, logic [31:0] addr, logic [31:0] rt,
                               logic [4:0] wba, logic [31:0] pc8, logic rst);
    logic [31:0] rnd;
    logic [31:0] instr;
    logic        expMis;
    logic [31:0] expDm;
    logic        isMem;
    rnd   = $urandom();
    instr = {op, rnd[25:0]};
    @(negedge clk);
    reset       = rst;
    bus.Instr_M = instr;
    bus.RT_M    = rt;
    bus.ALU_M   = addr;
    bus.PC8_M   = pc8;
    bus.WBA_M   = wba;
    #1;
    isMem  = (op == OP_LW || op == OP_LH || op == OP_LHU || op == OP_LB ||
              op == OP_LBU || op == OP_SW || op == OP_SH || op == OP_SB);
    expMis = isMem && refMisaligned(op, addr);
    expDm  = refLoad(op, addr);
    checkOutput("Misalign_M", {31'h0, bus.Misalign_M}, {31'h0, expMis});
    if (rst) refClear();
    else     refStore(op, addr, rt);
    @(posedge clk);
    #1;
    checkOutput("Instr_W", bus.Instr_W, rst ? 32'h0 : instr);
    checkOutput("ALU_W",   bus.ALU_W,   rst ? 32'h0 : addr);
    checkOutput("DM_W",    bus.DM_W,    rst ? 32'h0 : expDm);
    checkOutput("PC8_W",   bus.PC8_W,   rst ? 32'h0 : pc8);
    checkOutput("WBA_W",   {27'h0, bus.WBA_W}, rst ? 32'h0 : {27'h0, wba});
    checkOutput("Exc_W",   {31'h0, bus.Exc_W}, rst ? 32'h0 : {31'h0, expMis});
  endtask

  logic [5:0] opTable [10];

  initial begin
    logic [31:0] a;
    logic [31:0] r;
    logic [5:0]  op;
    checks = 0;
    errors = 0;
    opTable = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB,
                6'b000000, 6'b001000};
    refClear();
    reset       = 1'b1;
    bus.Instr_M = '0;
    bus.RT_M    = '0;
    bus.ALU_M   = '0;
    bus.PC8_M   = '0;
    bus.WBA_M   = '0;

    $display("[TB] reset and basic word access");
    applyStimulus(6'b000000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1);
    applyStimulus(OP_LW, 32'h0,  32'h0,        5'd3, 32'h0000_0008, 1'b0);
    checkOutput("tp_lw0", bus.DM_W, 32'h0000_0000);
    applyStimulus(OP_SW, 32'h10, 32'h12345678, 5'd0, 32'h0000_000C, 1'b0);
    applyStimulus(OP_LW, 32'h10, 32'h0,        5'd9, 32'h0000_0010, 1'b0);
    checkOutput("tp_lw10", bus.DM_W, 32'h12345678);

    $display("[TB] byte and halfword access");
    applyStimulus(OP_SB,  32'h11, 32'h000000AB, 5'd0, 32'h14, 1'b0);
    applyStimulus(OP_LW,  32'h10, 32'h0, 5'd1, 32'h18, 1'b0);
    checkOutput("tp_sb_word", bus.DM_W, 32'h1234AB78);
    applyStimulus(OP_LB,  32'h11, 32'h0, 5'd2, 32'h1C, 1'b0);
    checkOutput("tp_lb", bus.DM_W, 32'hFFFFFFAB);
    applyStimulus(OP_LBU, 32'h11, 32'h0, 5'd3, 32'h20, 1'b0);
    checkOutput("tp_lbu", bus.DM_W, 32'h000000AB);
    applyStimulus(OP_SH,  32'h12, 32'h00008001, 5'd0, 32'h24, 1'b0);
    applyStimulus(OP_LW,  32'h10, 32'h0, 5'd4, 32'h28, 1'b0);
    checkOutput("tp_sh_word", bus.DM_W, 32'h8001AB78);
    applyStimulus(OP_LH,  32'h12, 32'h0, 5'd5, 32'h2C, 1'b0);
    checkOutput("tp_lh", bus.DM_W, 32'hFFFF8001);
    applyStimulus(OP_LHU, 32'h12, 32'h0, 5'd6, 32'h30, 1'b0);
    checkOutput("tp_lhu", bus.DM_W, 32'h00008001);

    $display("[TB] misaligned accesses");
    applyStimulus(OP_SW, 32'h13, 32'hCAFEF00D, 5'd0, 32'h34, 1'b0);
    checkOutput("tp_exc_sw", {31'h0, bus.Exc_W}, 32'h1);
    applyStimulus(OP_LH, 32'h11, 32'h0, 5'd7, 32'h38, 1'b0);
    checkOutput("tp_exc_lh", {31'h0, bus.Exc_W}, 32'h1);
    checkOutput("tp_lh_mis", bus.DM_W, 32'h0);
    applyStimulus(OP_LW, 32'h10, 32'h0, 5'd8, 32'h3C, 1'b0);
    checkOutput("tp_unchanged", bus.DM_W, 32'h8001AB78);

    $display("[TB] store under reset and address wrap");
    applyStimulus(OP_SW, 32'h20, 32'hDEADBEEF, 5'd0, 32'h40, 1'b1);
    applyStimulus(OP_LW, 32'h20, 32'h0, 5'd10, 32'h44, 1'b0);
    checkOutput("tp_rst_store", bus.DM_W, 32'h0);
    applyStimulus(OP_SW, 32'h4020, 32'h5A5A1234, 5'd0, 32'h48, 1'b0);
    applyStimulus(OP_LW, 32'h20,   32'h0, 5'd11, 32'h4C, 1'b0);
    checkOutput("tp_wrap", bus.DM_W, 32'h5A5A1234);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      op = opTable[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0)
        a = $urandom();
      else
        a = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
      r = $urandom();
      applyStimulus(op, a, r, 5'($urandom_range(0, 31)), $urandom(),
                    ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipelined MIPS CPU, sitting directly downstream of the EX/MEM register. It consumes the EX/MEM outputs: instruction, forwarded store data, ALU address, PC+8 and write-back address. It performs word, halfword and byte loads and stores against an internal data memory, sign- or zero-extends load data, and registers everything into the MEM/WB pipeline register for the write-back stage. It also flags misaligned accesses.

## Interface
Parameters:
- DM_WORDS, 4096, data-memory depth in 32-bit words (16 KiB)
- ADDR_W, 12, word-index width; must equal log2(DM_WORDS)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- Instr_M  in  32  instruction in MEM
- RT_M  in  32  store data, already forwarded
- ALU_M  in  32  effective byte address
- PC8_M  in  32  PC+8 of instruction in MEM
- WBA_M  in  5  destination register of instruction in MEM
- Instr_W  out  32  registered Instr_M
- ALU_W  out  32  registered ALU_M
- DM_W  out  32  registered, extended load data
- PC8_W  out  32  registered PC8_M
- WBA_W  out  5  registered WBA_M
- Exc_W  out  1  registered misalignment flag
- Misalign_M  out  1  combinational misalignment flag for the current MEM instruction

## Operation
- The opcode is Instr_M[31:26]. Stores: sw 101011, sh 101001, sb 101000. Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100. Any other opcode performs no memory access and drives load data 0.
- The word index is ALU_M[ADDR_W+1:2]. Upper address bits are ignored, so accesses wrap modulo 16 KiB.
- Byte lane is ALU_M[1:0]. The memory is little-endian: byte 0 is bits [7:0].
- Alignment rules:
  - Word access is misaligned if ALU_M[1:0] != 0.
  - Halfword access is misaligned if ALU_M[0] = 1.
  - Byte access is never misaligned.
- Misalign_M = 1 only for a misaligned load or store opcode.
- Store byte enables:
  - sw writes all 4 lanes with RT_M.
  - sh writes lanes {1,0} or {3,2}, selected by ALU_M[1], with RT_M[15:0].
  - sb writes the single lane ALU_M[1:0] with RT_M[7:0].
  - Unselected lanes are preserved.
  - A misaligned store writes nothing.
- Load read is combinational from the array. Lane select and extension:
  - lw returns the word.
  - lh and lb sign-extend.
  - lhu and lbu zero-extend.
  - A misaligned load returns 0.
- MEM/WB register: on each edge without reset, every *_W output takes its *_M value or computed value. DM_W takes the extended load data; Exc_W takes Misalign_M.
- No stall or flush inputs; the stage advances every cycle.

## Timing
- Reset, on an edge with reset = 1:
  - All *_W outputs become 0.
  - Every memory word becomes 0.
  - Any store presented that cycle is discarded.
- Store commits at the rising edge ending the cycle in which it is in MEM.
- A load in cycle N+1 to an address stored in cycle N returns the new data; no bypass is needed.
- Load latency: DM_W is valid one cycle after the load is in MEM. Misalign_M is same-cycle and Exc_W is one cycle later.
- Reset released mid-program: the first edge with reset = 0 captures whatever is on the *_M inputs. The upstream EX/MEM register is itself zero after reset, i.e. a nop.
- Initial simulation state equals the reset state.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB)
  - DM_WORDS / ADDR_W defaults
  - a 4-bit byte-enable type
- Sub-module `dm_ram`: DM_WORDS x 32 array with 4-bit byte-enable synchronous write, synchronous clear on reset, and combinational read port.
- Decode, lane select, extension and the MEM/WB register live in mem_stage.

## Test plan
- Reset for 1 cycle -> all *_W = 0, Exc_W = 0. lw 0x0 then gives DM_W = 0x00000000.
- sw RT=0x12345678 at 0x10, next cycle lw 0x10 -> DM_W = 0x12345678 one cycle after the lw; WBA_W and PC8_W track the inputs.
- Following test 2:
  - sb RT=0x000000AB at 0x11 -> word 0x1234AB78.
  - lb 0x11 -> DM_W = 0xFFFFFFAB.
  - lbu 0x11 -> DM_W = 0x000000AB.
- Following test 3:
  - sh RT=0x00008001 at 0x12 -> word 0x8001AB78.
  - lh 0x12 -> DM_W = 0xFFFF8001.
  - lhu 0x12 -> DM_W = 0x00008001.
- Misaligned sw at 0x13 and lh at 0x11 -> Misalign_M = 1 same cycle and Exc_W = 1 next cycle. The word at 0x10 is unchanged (0x8001AB78) and the lh gives DM_W = 0.
- sw 0xDEADBEEF at 0x20 with reset = 1 the same cycle -> lw 0x20 after reset gives DM_W = 0. Address 0x4020 aliases 0x20 (wrap check).
